rv_lsu: RTL and testbench

Load/store unit between the rv core datapath and the word-organised memory.
- Accepts one byte/half/word load or store per request from the core.
- Converts it into a single word-aligned memory transaction with byte strobes, then waits for the memory's registered data-ready.
- Returns the extracted, sign- or zero-extended load data, or a fault, to the core over a valid/ready handshake.

---
 rtl/rv_lsu_pkg.sv | 40 ++++
 rtl/rv_lsu_align.sv | 31 +++
 rtl/rv_lsu.sv | 205 ++++++++++++++++++++
 tb/tb_rv_lsu.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_lsu_pkg.sv
// rv_lsu_pkg: shared definitions for the load/store unit.
//   - funct3 encodings for byte/half/word loads and stores
//   - lsu_state_t: LSU control state encoding
//   - f3_legal(): funct3 legality for a load or a store
//   - f3_misaligned(): natural-alignment check for a width and byte offset
package rv_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_t;

   // Stores only have signed encodings; loads add the unsigned byte/half.
   function automatic logic f3_legal(input logic write, input logic [2:0] funct3);
      logic ok;
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      if (!write) begin
         ok = ok || (funct3 == F3_BU) || (funct3 == F3_HU);
      end
      return ok;
   endfunction

   // funct3[1:0] carries the access width for every legal encoding.
   function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [1:0] a);
      logic bad;
      bad = 1'b0;
      if (funct3[1:0] == 2'b01) bad = a[0];
      if (funct3[1:0] == 2'b10) bad = (a != 2'b00);
      return bad;
   endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// rv_lsu_align: load data extraction.
//   mem_rdata in 32  memory word as read
//   offset    in 2   byte offset of the access inside the word
//   funct3    in 3   load type (LB/LH/LW/LBU/LHU)
//   rdata     out 32 shifted and sign/zero-extended result
// Purely combinational so it can be shared with the fetch path.
module rv_lsu_align
   import rv_lsu_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata
);

   logic [31:0] shifted;

   assign shifted = mem_rdata >> {offset, 3'b000};

   always_comb begin
      rdata = shifted;
      case (funct3)
         F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   rdata = {24'd0, shifted[7:0]};
         F3_HU:   rdata = {16'd0, shifted[15:0]};
         default: rdata = shifted;
      endcase
   end

endmodule

// File: rtl/rv_lsu.sv
// rv_lsu: load/store unit between the core datapath and word-organised memory.
// Each request becomes one word-aligned memory access with byte strobes; the
// extended load data (or a fault) is returned over a response handshake.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   req_valid/req_ready  request handshake (req_ready high only in IDLE)
//   req_write            1 = store, 0 = load
//   req_funct3           RISC-V funct3 of the access
//   req_addr             byte address
//   req_wdata            store data (rs2)
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            extended load data; 0 for stores and faults
//   rsp_fault            illegal funct3, timeout, or (trap build) misalignment
//   mem_addr             word-aligned address, valid ISSUE..WAIT
//   mem_wdata, mem_wstrb lane-replicated store data and byte strobes
//   mem_write            write enable, one-cycle pulse in ISSUE
//   mem_addr_ready       address-valid pulse in ISSUE
//   mem_rdata            registered memory read data
//   mem_data_ready       memory data valid; only observed in WAIT
//   state_dbg            current control state (lsu_state_t encoding)
//
// Parameters: ADDR_W address width; TIMEOUT WAIT cycles before a fault
// response (0 disables the timeout).
//
// Build option RV_LSU_MISALIGN_TRAP_EN: when defined, misaligned half/word
// requests fault straight from IDLE with no memory access. When undefined,
// the address low bits are truncated to natural alignment instead.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds valid and its payload stable until that
// edge; rsp_valid/rsp_rdata/rsp_fault never change while waiting for rsp_ready.
module rv_lsu
   import rv_lsu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_fault,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   output logic              mem_write,
   output logic              mem_addr_ready,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_data_ready,
   output logic [1:0]        state_dbg
);

   lsu_state_t        state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        f3_q;
   logic              write_q;
   logic [31:0]       wdata_q;
   logic [31:0]       wait_cnt;
   logic [31:0]       rdata_q;
   logic              fault_q;

   logic              req_fire;
   logic              req_bad;
   logic              timeout_hit;
   logic              mem_active;
   logic [1:0]        eff_off;
   logic [3:0]        wstrb_c;
   logic [31:0]       wdata_c;
   logic [31:0]       load_data;

   assign req_fire  = req_valid && req_ready;
   assign state_dbg = state;

`ifdef RV_LSU_MISALIGN_TRAP_EN
   assign req_bad = !f3_legal(req_write, req_funct3) ||
                    f3_misaligned(req_funct3, req_addr[1:0]);
`else
   assign req_bad = !f3_legal(req_write, req_funct3);
`endif

   // Offset truncated to natural alignment; for aligned requests this is just
   // addr[1:0], and misaligned ones only get here in the non-trap build.
   always_comb begin
      eff_off = 2'b00;
      case (f3_q[1:0])
         2'b00:   eff_off = addr_q[1:0];
         2'b01:   eff_off = {addr_q[1], 1'b0};
         default: eff_off = 2'b00;
      endcase
   end

   always_comb begin
      wstrb_c = 4'b0000;
      wdata_c = wdata_q;
      case (f3_q[1:0])
         2'b00: begin
            wstrb_c = 4'b0001 << eff_off;
            wdata_c = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            wstrb_c = 4'b0011 << eff_off;
            wdata_c = {2{wdata_q[15:0]}};
         end
         default: begin
            wstrb_c = 4'b1111;
            wdata_c = wdata_q;
         end
      endcase
      if (!write_q) wstrb_c = 4'b0000;
   end

   rv_lsu_align u_align (
      .mem_rdata (mem_rdata),
      .offset    (eff_off),
      .funct3    (f3_q),
      .rdata     (load_data)
   );

   assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == 32'(TIMEOUT - 1));

   // Memory-side outputs are decoded from state so an asynchronous reset
   // removes any in-flight write or address pulse immediately.
   assign mem_active = (state == ST_ISSUE) || (state == ST_WAIT);
   assign mem_addr   = mem_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign mem_wdata  = mem_active ? wdata_c : 32'd0;
   assign mem_wstrb  = mem_active ? wstrb_c : 4'd0;
   assign rsp_rdata  = (state == ST_RESP) ? rdata_q : 32'd0;
   assign rsp_fault  = (state == ST_RESP) ? fault_q : 1'b0;

   always_comb begin
      state_nxt      = state;
      req_ready      = 1'b0;
      rsp_valid      = 1'b0;
      mem_addr_ready = 1'b0;
      mem_write      = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = req_bad ? ST_RESP : ST_ISSUE;
         end
         ST_ISSUE: begin
            mem_addr_ready = 1'b1;
            mem_write      = write_q;
            state_nxt      = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_data_ready || timeout_hit) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         addr_q   <= '0;
         f3_q     <= 3'd0;
         write_q  <= 1'b0;
         wdata_q  <= 32'd0;
         wait_cnt <= 32'd0;
         rdata_q  <= 32'd0;
         fault_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (req_fire) begin
                  addr_q  <= req_addr;
                  f3_q    <= req_funct3;
                  write_q <= req_write;
                  wdata_q <= req_wdata;
                  rdata_q <= 32'd0;
                  fault_q <= req_bad;
               end
            end
            ST_ISSUE: wait_cnt <= 32'd0;
            ST_WAIT: begin
               if (mem_data_ready) begin
                  rdata_q <= write_q ? 32'd0 : load_data;
                  fault_q <= 1'b0;
               end else if (timeout_hit) begin
                  rdata_q <= 32'd0;
                  fault_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: directed bench for rv_lsu with a word memory stub.
// Builds with or without RV_LSU_MISALIGN_TRAP_EN; the misaligned-halfword
// vector picks its expected result accordingly.
module tb_rv_lsu;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_write;
   logic        mem_addr_ready;
   logic [31:0] mem_rdata;
   logic        mem_data_ready;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   rv_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_rdata      (rsp_rdata),
      .rsp_fault      (rsp_fault),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_wstrb      (mem_wstrb),
      .mem_write      (mem_write),
      .mem_addr_ready (mem_addr_ready),
      .mem_rdata      (mem_rdata),
      .mem_data_ready (mem_data_ready),
      .state_dbg      (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memory stub ----------------
   logic [31:0] mem [0:63];
   logic        mem_stall;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_data_ready <= 1'b0;
         mem_rdata      <= 32'd0;
      end else begin
         mem_data_ready <= mem_addr_ready && !mem_stall;
         if (mem_addr_ready) mem_rdata <= mem[mem_addr[7:2]];
         if (mem_write) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_wstrb[b]) mem[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end
         end
      end
   end

   // ---------------- bus monitor ----------------
   int          n_addr_pulses = 0;
   int          n_write_pulses = 0;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_wstrb;

   always @(negedge clk) begin
      if (mem_addr_ready) n_addr_pulses++;
      if (mem_write) begin
         n_write_pulses++;
         cap_addr  = mem_addr;
         cap_wdata = mem_wdata;
         cap_wstrb = mem_wstrb;
      end
   end

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Called just after a rising edge with the DUT in IDLE. Returns the
   // response and its latency in cycles counted from the accepting edge.
   task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rdata, output logic fault,
                         output int lat, output int addr_pulses, output int wr_pulses);
      int a0, w0;
      a0 = n_addr_pulses;
      w0 = n_write_pulses;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      req_valid  = 1'b1;
      check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = rsp_rdata;
      fault = rsp_fault;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready   = 1'b0;
      addr_pulses = n_addr_pulses - a0;
      wr_pulses   = n_write_pulses - w0;
   endtask

   task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp_rdata);
      logic [31:0] rd;
      logic        ft;
      int          lat, ap, wp;
      do_req(tag, 1'b0, f3, addr, 32'd0, rd, ft, lat, ap, wp);
      check_eq({tag, "_rdata"}, rd, exp_rdata);
      check_eq({tag, "_fault"}, 32'(ft), 32'd0);
      check_eq({tag, "_lat"}, 32'(lat), 32'd3);
   endtask

   task automatic fault_chk(input string tag, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr);
      logic [31:0] rd;
      logic        ft;
      int          lat, ap, wp;
      do_req(tag, wr, f3, addr, 32'hFFFF_FFFF, rd, ft, lat, ap, wp);
      check_eq({tag, "_fault"}, 32'(ft), 32'd1);
      check_eq({tag, "_rdata"}, rd, 32'd0);
      check_eq({tag, "_lat"}, 32'(lat), 32'd1);
      check_eq({tag, "_no_mem"}, 32'(ap + wp), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rd;
      logic        ft;
      int          lat, ap, wp, n;

      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      mem[16] = 32'hDEAD_BEEF;  // 0x40
      mem[32] = 32'h1122_3344;  // 0x80
      mem_stall  = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      rsp_ready  = 1'b0;
      reset      = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_req_ready", 32'(req_ready), 32'd1);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
      check_eq("rst_mem_addr_ready", 32'(mem_addr_ready), 32'd0);
      check_eq("rst_mem_write", 32'(mem_write), 32'd0);
      check_eq("rst_mem_addr", mem_addr, 32'd0);
      check_eq("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      check_eq("rst_state", 32'(state_dbg), 32'd0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      // LW 0x40
      do_req("lw40", 1'b0, 3'b010, 32'h40, 32'd0, rd, ft, lat, ap, wp);
      check_eq("lw40_rdata", rd, 32'hDEAD_BEEF);
      check_eq("lw40_fault", 32'(ft), 32'd0);
      check_eq("lw40_lat", 32'(lat), 32'd3);
      check_eq("lw40_addr_pulses", 32'(ap), 32'd1);
      check_eq("lw40_wr_pulses", 32'(wp), 32'd0);

      load_chk("lb43",  3'b000, 32'h43, 32'hFFFF_FFDE);
      load_chk("lbu43", 3'b100, 32'h43, 32'h0000_00DE);

      // SB 0x12345678 to 0x41
      do_req("sb41", 1'b1, 3'b000, 32'h41, 32'h1234_5678, rd, ft, lat, ap, wp);
      check_eq("sb41_rdata", rd, 32'd0);
      check_eq("sb41_fault", 32'(ft), 32'd0);
      check_eq("sb41_wr_pulses", 32'(wp), 32'd1);
      check_eq("sb41_wstrb", 32'(cap_wstrb), 32'h2);
      check_eq("sb41_wdata", cap_wdata, 32'h7878_7878);
      check_eq("sb41_addr", cap_addr, 32'h40);
      load_chk("lw40b", 3'b010, 32'h40, 32'hDEAD_78EF);

      load_chk("lh42",  3'b001, 32'h42, 32'hFFFF_DEAD);
      load_chk("lhu42", 3'b101, 32'h42, 32'h0000_DEAD);

      // Misaligned halfword
`ifdef RV_LSU_MISALIGN_TRAP_EN
      fault_chk("lh41", 1'b0, 3'b001, 32'h41);
`else
      load_chk("lh41", 3'b001, 32'h41, 32'h0000_78EF);
`endif

      // SH 0xABCD to 0x46, then read back the word
      do_req("sh46", 1'b1, 3'b001, 32'h46, 32'h5555_ABCD, rd, ft, lat, ap, wp);
      check_eq("sh46_wstrb", 32'(cap_wstrb), 32'hC);
      check_eq("sh46_wdata", cap_wdata, 32'hABCD_ABCD);
      check_eq("sh46_wr_pulses", 32'(wp), 32'd1);
      load_chk("lw44", 3'b010, 32'h44, 32'hABCD_0000);

      // Illegal funct3
      fault_chk("ill_ld011", 1'b0, 3'b011, 32'h40);
      fault_chk("ill_ld111", 1'b0, 3'b111, 32'h40);
      fault_chk("ill_st100", 1'b1, 3'b100, 32'h40);

      // Timeout: memory never answers, TIMEOUT=4
      mem_stall = 1'b1;
      do_req("tmo", 1'b0, 3'b010, 32'h40, 32'd0, rd, ft, lat, ap, wp);
      mem_stall = 1'b0;
      check_eq("tmo_fault", 32'(ft), 32'd1);
      check_eq("tmo_rdata", rd, 32'd0);
      check_eq("tmo_lat", 32'(lat), 32'd6);

      // Reset asserted while a store is in ISSUE
      req_write  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h80;
      req_wdata  = 32'hCAFE_F00D;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_eq("rst_mid_write_before", 32'(mem_write), 32'd1);
      reset = 1'b1;
      #1;
      check_eq("rst_mid_write", 32'(mem_write), 32'd0);
      check_eq("rst_mid_addr_ready", 32'(mem_addr_ready), 32'd0);
      check_eq("rst_mid_req_ready", 32'(req_ready), 32'd1);
      check_eq("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      load_chk("lw80", 3'b010, 32'h80, 32'h1122_3344);

      // Response back-pressure: rsp_ready low for 5 cycles
      req_write  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h40;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("bp_valid_%0d", i), 32'(rsp_valid), 32'd1);
         check_eq($sformatf("bp_rdata_%0d", i), rsp_rdata, 32'hDEAD_78EF);
         check_eq($sformatf("bp_req_ready_%0d", i), 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      // Release the response with the next request already waiting.
      rsp_ready  = 1'b1;
      req_funct3 = 3'b100;
      req_addr   = 32'h40;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check_eq("bp_released", 32'(rsp_valid), 32'd0);
      check_eq("bp_idle_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_eq("bp_next_issue", 32'(mem_addr_ready), 32'd1);
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("bp_next_rdata", rsp_rdata, 32'h0000_00EF);
      check_eq("bp_next_lat", 32'(n), 32'd2);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
